// File: rtl/uart_packet_controller_if.sv
// Byte-stream input, register-write port and packet status of the UART packet controller.
interface uart_packet_controller_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       reg_write;
  logic [7:0] reg_address;
  logic [7:0] reg_data;
  logic       reg_ready;
  logic       busy;
  logic       packet_done;
  logic       packet_error;
  logic [1:0] error_code;

  modport master (
    input  rx_valid, rx_data, reg_ready,
    output reg_write, reg_address, reg_data, busy, packet_done, packet_error, error_code
  );

  modport slave (
    output rx_valid, rx_data, reg_ready,
    input  reg_write, reg_address, reg_data, busy, packet_done, packet_error, error_code
  );
endinterface

// File: rtl/uart_packet_controller.sv
// Frames SYNC/ADDRESS/LENGTH/payload packets from a UART byte stream into register writes.
// Define UART_PACKET_CHECKSUM_EN for buffered mode with a trailing XOR checksum byte.
module uart_packet_controller #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LENGTH     = 16,
  parameter int unsigned TIMEOUT_CLOCKS = 100000
) (
  input logic                      clock,
  input logic                      reset,
  uart_packet_controller_if.master bus
);
  localparam int unsigned  TW      = (TIMEOUT_CLOCKS > 2) ? $clog2(TIMEOUT_CLOCKS) : 1;
  localparam logic [TW-1:0] RELOAD = (TIMEOUT_CLOCKS == 0) ? '0 : TW'(TIMEOUT_CLOCKS - 1);
  localparam logic [7:0]   MAX_LEN = 8'(MAX_LENGTH);
  localparam logic [1:0]   ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]   ERR_LENGTH  = 2'd2;
  localparam logic [1:0]   ERR_DATA    = 2'd3;

  typedef enum logic [2:0] {IDLE, ADDRESS, LENGTH, DATA, CHECK, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d, len_q, len_d, idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          write_q, write_d;
  logic [7:0]    waddr_q, waddr_d, wdata_q, wdata_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          expired, handshake;

`ifdef UART_PACKET_CHECKSUM_EN
  localparam int unsigned BW = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
  logic [7:0] buffer_q [MAX_LENGTH];
  logic [7:0] csum_q, csum_d;
  logic       buf_we;
`endif

  assign expired   = (TIMEOUT_CLOCKS != 0) && (timer_q == '0);
  assign handshake = write_q && bus.reg_ready;

  // Next-state, write-port and status decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    write_d = write_q && !bus.reg_ready;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
`ifdef UART_PACKET_CHECKSUM_EN
    csum_d  = csum_q;
    buf_we  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d = ADDRESS;
          timer_d = RELOAD;
        end
      end
      ADDRESS: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data;
          timer_d = RELOAD;
          state_d = LENGTH;
`ifdef UART_PACKET_CHECKSUM_EN
          csum_d  = bus.rx_data;
`endif
        end else if (expired) begin
          state_d = IDLE; err_d = 1'b1; code_d = ERR_TIMEOUT;
        end
      end
      LENGTH: begin
        if (bus.rx_valid) begin
          if ((bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN)) begin
            state_d = IDLE; err_d = 1'b1; code_d = ERR_LENGTH;
          end else begin
            len_d   = bus.rx_data;
            idx_d   = 8'd0;
            timer_d = RELOAD;
            state_d = DATA;
`ifdef UART_PACKET_CHECKSUM_EN
            csum_d  = csum_q ^ bus.rx_data;
`endif
          end
        end else if (expired) begin
          state_d = IDLE; err_d = 1'b1; code_d = ERR_TIMEOUT;
        end
      end
`ifdef UART_PACKET_CHECKSUM_EN
      DATA: begin
        if (bus.rx_valid) begin
          buf_we  = 1'b1;
          csum_d  = csum_q ^ bus.rx_data;
          idx_d   = idx_q + 8'd1;
          timer_d = RELOAD;
          if (idx_q == len_q - 8'd1) state_d = CHECK;
        end else if (expired) begin
          state_d = IDLE; err_d = 1'b1; code_d = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d = FLUSH;
            write_d = 1'b1;
            waddr_d = addr_q;
            wdata_d = buffer_q[0];
            idx_d   = 8'd1;
          end else begin
            state_d = IDLE; err_d = 1'b1; code_d = ERR_DATA;
          end
        end else if (expired) begin
          state_d = IDLE; err_d = 1'b1; code_d = ERR_TIMEOUT;
        end
      end
      FLUSH: begin
        // One write per clock while reg_ready stays high; incoming bytes are dropped.
        if (handshake) begin
          if (idx_q == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            write_d = 1'b1;
            waddr_d = addr_q + idx_q;
            wdata_d = buffer_q[idx_q[BW-1:0]];
            idx_d   = idx_q + 8'd1;
          end
        end
      end
`else
      DATA: begin
        // idx_q == len_q means every byte arrived and only the last write is outstanding.
        if (bus.rx_valid && (idx_q != len_q)) begin
          timer_d = RELOAD;
          if (write_q && !bus.reg_ready) begin
            state_d = IDLE; err_d = 1'b1; code_d = ERR_DATA; write_d = 1'b0;
          end else begin
            write_d = 1'b1;
            waddr_d = addr_q + idx_q;
            wdata_d = bus.rx_data;
            idx_d   = idx_q + 8'd1;
          end
        end else if ((idx_q == len_q) && handshake) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (expired) begin
          state_d = IDLE; err_d = 1'b1; code_d = ERR_TIMEOUT; write_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
`ifdef UART_PACKET_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef UART_PACKET_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

`ifdef UART_PACKET_CHECKSUM_EN
  // Payload storage; contents are only read after being written in the same packet.
  always_ff @(posedge clock) begin
    if (buf_we) buffer_q[idx_q[BW-1:0]] <= bus.rx_data;
  end
`endif

  assign bus.reg_write    = write_q;
  assign bus.reg_address  = waddr_q;
  assign bus.reg_data     = wdata_q;
  assign bus.busy         = busy_q;
  assign bus.packet_done  = done_q;
  assign bus.packet_error = err_q;
  assign bus.error_code   = code_q;
endmodule

// File: tb/tb_uart_packet_controller.sv
// Self-checking bench for uart_packet_controller: directed vector table, corner sequences, random packets.
module tb_uart_packet_controller;
  localparam int unsigned MAXL = 16;
  localparam int unsigned TMO  = 40;
`ifdef UART_PACKET_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_packet_controller_if bus();
  uart_packet_controller #(.SYNC_BYTE(8'hA5), .MAX_LENGTH(MAXL), .TIMEOUT_CLOCKS(TMO)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, exp_total = 0;
  logic [1:0] last_code = 2'd0;
  logic [7:0] wa_q[$], wd_q[$], exp_wa[$], exp_wd[$], pkt_b[$];
  int pkt_g[$];
  logic ready_val = 1'b1;
  bit   rnd_ready = 1'b0;

  typedef struct packed {
    logic [3:0]  n;
    logic [79:0] bytes;
    logic [1:0]  code;
    logic [1:0]  nw;
    logic [23:0] wa;
    logic [23:0] wd;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clock) cyc <= cyc + 1;

  // Observe completed writes and status pulses.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.reg_write && bus.reg_ready) begin
        wa_q.push_back(bus.reg_address);
        wd_q.push_back(bus.reg_data);
      end
      if (bus.packet_done) done_cnt++;
      if (bus.packet_error) begin
        err_cnt++;
        err_cyc   = cyc;
        last_code = bus.error_code;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.reg_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
    @(posedge clock);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int g);
    pkt_b.push_back(b);
    pkt_g.push_back(g);
  endtask

  task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic run_packet(input string name, input int exp_done, input int exp_err, input logic [1:0] exp_code);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int w0 = wa_q.size();
    int k  = 0;
    for (int i = 0; i < pkt_b.size(); i++) begin
      for (int g = 1; g < pkt_g[i]; g++) tick(1'b0, 8'h00);
      tick(1'b1, pkt_b[i]);
    end
    while ((done_cnt + err_cnt - d0 - e0) < (exp_done + exp_err) && k < 3000) begin
      tick(1'b0, 8'h00);
      k++;
    end
    check({name, "_wait"}, int'((done_cnt + err_cnt - d0 - e0) >= (exp_done + exp_err)), 1);
    repeat (4) tick(1'b0, 8'h00);
    check({name, "_done"}, done_cnt - d0, exp_done);
    check({name, "_err"}, err_cnt - e0, exp_err);
    if (exp_err > 0) check({name, "_code"}, int'(last_code), int'(exp_code));
    check({name, "_nwr"}, wa_q.size() - w0, exp_wa.size());
    for (int i = 0; i < exp_wa.size() && (w0 + i) < wa_q.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), int'(wa_q[w0 + i]), int'(exp_wa[i]));
      check($sformatf("%s_data%0d", name, i), int'(wd_q[w0 + i]), int'(exp_wd[i]));
    end
    check({name, "_busy"}, int'(bus.busy), 0);
    exp_total += exp_done + exp_err;
    pkt_b.delete(); pkt_g.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr"},   int'(bus.reg_write), 0);
    check({name, "_addr"}, int'(bus.reg_address), 0);
    check({name, "_data"}, int'(bus.reg_data), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_done"}, int'(bus.packet_done), 0);
    check({name, "_perr"}, int'(bus.packet_error), 0);
    check({name, "_code"}, int'(bus.error_code), 0);
  endtask

  function automatic vec_t mk(input int n, input logic [79:0] b, input logic [1:0] code,
                              input int nw, input logic [23:0] wa, input logic [23:0] wd);
    vec_t v;
    v.n = 4'(n); v.bytes = b; v.code = code; v.nw = 2'(nw); v.wa = wa; v.wd = wd;
    return v;
  endfunction

  initial begin
    logic [79:0] bb;
    logic [7:0]  seq[$];
    logic [7:0]  cs, addr, b;
    int e0, w0, d0, bc, k, len, tc, full;
    bit bad, corrupt;

    if (CSUM) begin
      vecs[0] = mk(7, 80'hA5_10_03_11_22_33_13_00_00_00, 2'd0, 3, 24'h10_11_12, 24'h11_22_33);
      vecs[1] = mk(7, 80'hA5_FE_03_01_02_03_FD_00_00_00, 2'd0, 3, 24'hFE_FF_00, 24'h01_02_03);
      vecs[4] = mk(6, 80'h33_A5_10_01_A5_B4_00_00_00_00, 2'd0, 1, 24'h10_00_00, 24'hA5_00_00);
      vecs[5] = mk(5, 80'hA5_10_01_55_00_00_00_00_00_00, 2'd3, 0, 24'h0, 24'h0);
    end else begin
      vecs[0] = mk(6, 80'hA5_10_03_11_22_33_00_00_00_00, 2'd0, 3, 24'h10_11_12, 24'h11_22_33);
      vecs[1] = mk(6, 80'hA5_FE_03_01_02_03_00_00_00_00, 2'd0, 3, 24'hFE_FF_00, 24'h01_02_03);
      vecs[4] = mk(5, 80'h33_A5_10_01_A5_00_00_00_00_00, 2'd0, 1, 24'h10_00_00, 24'hA5_00_00);
      vecs[5] = mk(4, 80'hA5_FF_01_5A_00_00_00_00_00_00, 2'd0, 1, 24'hFF_00_00, 24'h5A_00_00);
    end
    vecs[2] = mk(3, 80'hA5_00_00_00_00_00_00_00_00_00, 2'd2, 0, 24'h0, 24'h0);
    vecs[3] = mk(3, 80'hA5_00_11_00_00_00_00_00_00_00, 2'd2, 0, 24'h0, 24'h0);

    reset = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.reg_ready = 1'b1;
    repeat (3) tick(1'b0, 8'h00);
    check_reset_outputs("rst");
    reset = 1'b0;
    tick(1'b0, 8'h00);

    for (int v = 0; v < 6; v++) begin
      bb = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].n); i++) push(bb[79 - 8*i -: 8], 1);
      for (int i = 0; i < int'(vecs[v].nw); i++)
        exp_w(vecs[v].wa[23 - 8*i -: 8], vecs[v].wd[23 - 8*i -: 8]);
      run_packet($sformatf("vec%0d", v), (vecs[v].code == 2'd0) ? 1 : 0,
                 (vecs[v].code == 2'd0) ? 0 : 1, vecs[v].code);
    end

    // Inter-byte timeout: pulse exactly TMO clocks after the last accepted byte.
    e0 = err_cnt; w0 = wa_q.size(); k = 0;
    tick(1'b1, 8'hA5); tick(1'b1, 8'h20); bc = cyc;
    while (err_cnt == e0 && k < int'(TMO) + 20) begin tick(1'b0, 8'h00); k++; end
    check("tmo_seen", err_cnt - e0, 1);
    check("tmo_latency", err_cyc - bc, int'(TMO));
    check("tmo_code", int'(last_code), 1);
    check("tmo_nwr", wa_q.size() - w0, 0);
    exp_total += 1;
    push(8'hA5, 1); push(8'h40, 1); push(8'h01, 1); push(8'h77, 1);
    if (CSUM) push(8'h36, 1);
    exp_w(8'h40, 8'h77);
    run_packet("after_tmo", 1, 0, 2'd0);

    // A byte landing on the expiry cycle is still accepted.
    push(8'hA5, 1); push(8'h50, 1); push(8'h01, TMO); push(8'h66, TMO);
    if (CSUM) push(8'h37, TMO);
    exp_w(8'h50, 8'h66);
    run_packet("expiry_edge", 1, 0, 2'd0);

    // SYNC arriving in the packet_done cycle starts the next packet.
    push(8'hA5, 1); push(8'h60, 1); push(8'h01, 1); push(8'h88, 1);
    if (CSUM) push(8'hE9, 1);
    push(8'hA5, 2); push(8'h61, 1); push(8'h01, 1); push(8'h99, 1);
    if (CSUM) push(8'hF9, 1);
    exp_w(8'h60, 8'h88); exp_w(8'h61, 8'h99);
    run_packet("b2b", 2, 0, 2'd0);

    // Maximum legal length.
    cs = 8'hC0 ^ 8'h10;
    push(8'hA5, 1); push(8'hC0, 1); push(8'h10, 1);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 7 + 1);
      push(b, 1); cs = cs ^ b; exp_w(8'(8'hC0 + i), b);
    end
    if (CSUM) push(cs, 1);
    run_packet("maxlen", 1, 0, 2'd0);

    if (!CSUM) begin
      ready_val = 1'b0;
      push(8'hA5, 1); push(8'h10, 1); push(8'h03, 1); push(8'h11, 1); push(8'h22, 1);
      run_packet("overrun", 0, 1, 2'd3);
      check("overrun_withdrawn", int'(bus.reg_write), 0);
      ready_val = 1'b1;
    end else begin
      // Bytes arriving while the flush is stalled are dropped.
      ready_val = 1'b0;
      foreach (vecs[0].bytes[i]) begin end
      tick(1'b1, 8'hA5); tick(1'b1, 8'h10); tick(1'b1, 8'h02);
      tick(1'b1, 8'h11); tick(1'b1, 8'h22); tick(1'b1, 8'h21);
      tick(1'b1, 8'hA5); tick(1'b1, 8'h33); tick(1'b1, 8'h01);
      repeat (5) tick(1'b0, 8'h00);
      ready_val = 1'b1;
      exp_w(8'h10, 8'h11); exp_w(8'h11, 8'h22);
      run_packet("flush_drop", 1, 0, 2'd0);
    end

    // Reset with a write pending drops the packet silently.
    ready_val = 1'b0;
    d0 = done_cnt + err_cnt; w0 = wa_q.size();
    tick(1'b1, 8'hA5); tick(1'b1, 8'h10); tick(1'b1, CSUM ? 8'h01 : 8'h03); tick(1'b1, 8'h11);
    if (CSUM) tick(1'b1, 8'h00);
    tick(1'b0, 8'h00);
    check("pre_reset_wr", int'(bus.reg_write), 1);
    reset = 1'b1;
    tick(1'b0, 8'h00);
    check_reset_outputs("midrst");
    reset = 1'b0;
    ready_val = 1'b1;
    repeat (TMO + 10) tick(1'b0, 8'h00);
    check("midrst_pulses", done_cnt + err_cnt - d0, 0);
    check("midrst_nwr", wa_q.size() - w0, 0);

    // Random packets against a packet-level model.
    rnd_ready = CSUM;
    for (int n = 0; n < 60; n++) begin
      seq.delete();
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        push(b, $urandom_range(1, 3));
      end
      addr = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 9);
      len = (k == 0) ? 0 : (k == 1) ? $urandom_range(17, 255) : $urandom_range(1, 16);
      bad = (len == 0) || (len > int'(MAXL));
      seq.push_back(8'hA5); seq.push_back(addr); seq.push_back(8'(len));
      cs = addr ^ 8'(len);
      corrupt = 1'b0;
      if (!bad) begin
        for (int j = 0; j < len; j++) begin
          b = 8'($urandom_range(0, 255));
          seq.push_back(b); cs = cs ^ b;
        end
        if (CSUM) begin
          corrupt = ($urandom_range(0, 4) == 0);
          if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
          seq.push_back(cs);
        end
      end
      full = seq.size();
      tc = ($urandom_range(0, 5) == 0) ? $urandom_range(1, full - 1) : full;
      for (int j = 0; j < tc; j++)
        push(seq[j], ($urandom_range(0, 7) == 0) ? int'(TMO) : $urandom_range(1, 3));
      if (tc < full) begin
        if (!CSUM)
          for (int j = 3; j < tc; j++) exp_w(8'(addr + 8'(j - 3)), seq[j]);
        run_packet($sformatf("rnd%0d", n), 0, 1, 2'd1);
      end else if (bad) begin
        run_packet($sformatf("rnd%0d", n), 0, 1, 2'd2);
      end else if (corrupt) begin
        run_packet($sformatf("rnd%0d", n), 0, 1, 2'd3);
      end else begin
        for (int j = 0; j < len; j++) exp_w(8'(addr + 8'(j)), seq[3 + j]);
        run_packet($sformatf("rnd%0d", n), 1, 0, 2'd0);
      end
    end
    rnd_ready = 1'b0;

    repeat (TMO + 10) tick(1'b0, 8'h00);
    check("total_pulses", done_cnt + err_cnt, exp_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
